// File: rtl/serial_addsub.sv
// Bit-serial LSB-first add/subtract: one full-adder cell plus a carry flop reused over WIDTH clocks.
// Optional: define SERIAL_ADDSUB_SAT_EN to saturate r on signed overflow.
module serial_addsub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] r,
    output logic             co,
    output logic             ovf
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic             r_cin_msb;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_r;
    logic             r_co;
    logic             r_ovf;
`ifdef SERIAL_ADDSUB_SAT_EN
    logic             r_amsb;
`endif

    logic             w_s;
    logic             w_c;
    logic             w_ovf;
    logic [WIDTH-1:0] w_res;

    // Single full-adder cell working on the current LSB pair.
    always_comb begin
        w_s = r_a[0] ^ r_b[0] ^ r_carry;
        w_c = (r_a[0] & r_b[0]) | (r_a[0] & r_carry) | (r_b[0] & r_carry);
    end

    // Final result selection; overflow is carry-in vs carry-out of the MSB.
    always_comb begin
        w_ovf = r_cin_msb ^ r_carry;
        w_res = r_acc;
`ifdef SERIAL_ADDSUB_SAT_EN
        if (w_ovf) begin
            // Overflow only when effective operands share a sign, so A's MSB gives the direction.
            w_res = r_amsb ? {1'b1, {(WIDTH-1){1'b0}}}
                           : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
    end

    // Control FSM and datapath; outputs are registered and only touched on DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_carry   <= 1'b0;
            r_cin_msb <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_r       <= '0;
            r_co      <= 1'b0;
            r_ovf     <= 1'b0;
`ifdef SERIAL_ADDSUB_SAT_EN
            r_amsb    <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= sub ? ~b : b;
                        r_carry <= sub;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= SHIFT;
`ifdef SERIAL_ADDSUB_SAT_EN
                        r_amsb  <= a[WIDTH-1];
`endif
                    end
                end
                SHIFT: begin
                    r_carry <= w_c;
                    r_a     <= {1'b0, r_a[WIDTH-1:1]};
                    r_b     <= {1'b0, r_b[WIDTH-1:1]};
                    r_acc   <= {w_s, r_acc[WIDTH-1:1]};
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == LAST) begin
                        r_cin_msb <= r_carry;
                        r_busy    <= 1'b0;
                        r_state   <= DONE;
                    end
                end
                DONE: begin
                    r_done  <= 1'b1;
                    r_r     <= w_res;
                    r_co    <= r_carry;
                    r_ovf   <= w_ovf;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign r    = r_r;
    assign co   = r_co;
    assign ovf  = r_ovf;

endmodule
